// File: rtl/freq_div_ctrl.sv
// Run controller for the programmable frequency divider: holds half-period and burst
// configuration, produces the divided clock, per-toggle ticks and burst-done pulses.
module freq_div_ctrl #(
  parameter int CNT_W        = 25,
  parameter int DEFAULT_HALF = 2700,
  parameter int PCNT_W       = 8
) (
  input  logic              C_50Mhz,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [PCNT_W-1:0] cfg_pulses,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              clk_out,
  output logic              tick,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_plus;
  logic [CNT_W-1:0]   half_reg, shadow_half, half_norm;
  logic [PCNT_W-1:0]  pulses_reg, remaining;
  logic               pending;
  logic               cfg_xfer, is_toggle, finish;

  // A zero half-period is stored as 1 so the toggle compare never needs a special case.
  assign half_norm = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign busy      = (state == RUN);

  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b1;
    is_toggle  = 1'b0;
    finish     = 1'b0;
    count_plus = count + 1'b1;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        cfg_ready = !pending;
        if (stop) begin
          state_nxt = IDLE;
        end else if (count_plus == half_reg) begin
          is_toggle = 1'b1;
          if (pulses_reg != '0 && remaining == PCNT_W'(1)) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
    endcase
    cfg_xfer = cfg_valid && cfg_ready;
  end

  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      clk_out     <= 1'b1;
      tick        <= 1'b0;
      done        <= 1'b0;
      half_reg    <= CNT_W'(DEFAULT_HALF);
      shadow_half <= CNT_W'(DEFAULT_HALF);
      pulses_reg  <= '0;
      remaining   <= '0;
      pending     <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (cfg_xfer) begin
          half_reg   <= half_norm;
          pulses_reg <= cfg_pulses;
        end
        if (start) begin
          count     <= '0;
          clk_out   <= 1'b1;
          remaining <= cfg_xfer ? cfg_pulses : pulses_reg;
        end
      end else if (stop) begin
        // A pending (or just-offered) shadow value must not be lost when the run aborts.
        count <= '0;
        if (pending) begin
          half_reg <= shadow_half;
          pending  <= 1'b0;
        end else if (cfg_xfer) begin
          half_reg <= half_norm;
        end
      end else if (is_toggle) begin
        count   <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
        done    <= finish;
        if (pulses_reg != '0) remaining <= remaining - 1'b1;
        if (pending) begin
          half_reg <= shadow_half;
          pending  <= 1'b0;
        end else if (cfg_xfer) begin
          shadow_half <= half_norm;
          pending     <= 1'b1;
        end
      end else begin
        count <= count_plus;
        if (cfg_xfer) begin
          shadow_half <= half_norm;
          pending     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: expected tick/done edges go into a scoreboard queue
// when a run is launched and are matched against the DUT by a negedge monitor.
module tb_freq_div_ctrl;

  localparam int CNT_W  = 25;
  localparam int PCNT_W = 8;

  logic              C_50Mhz = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic [PCNT_W-1:0] cfg_pulses = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              cfg_ready, busy, clk_out, tick, done;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int k, k2, k3;

  typedef struct {
    int   cycle;
    logic fin;
  } exp_t;
  exp_t exp_q[$];

  freq_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(2700), .PCNT_W(PCNT_W)) dut (
    .C_50Mhz   (C_50Mhz),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_pulses(cfg_pulses),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .clk_out   (clk_out),
    .tick      (tick),
    .done      (done)
  );

  always #10 C_50Mhz = ~C_50Mhz;

  always @(posedge C_50Mhz) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic v, input int half, input int pulses,
                                input logic st, input logic sp);
    cfg_valid  = v;
    cfg_half   = CNT_W'(half);
    cfg_pulses = PCNT_W'(pulses);
    start      = st;
    stop       = sp;
  endtask

  task automatic push_ticks(input int base, input int h, input int n, input logic finite);
    for (int i = 1; i <= n; i++) begin
      exp_t e;
      e.cycle = base + h * i;
      e.fin   = finite && (i == n);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge C_50Mhz);
    #1;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) step();
  endtask

  // Every tick/done is matched against the oldest scheduled edge; overdue entries count as missed.
  always @(negedge C_50Mhz) begin
    exp_t e;
    if (tick || done) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_tick", {30'd0, tick, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("tick_cycle", 32'(cyc), 32'(e.cycle));
        check_output("tick_done", 32'(done), 32'(e.fin));
        check_output("tick_pulse", 32'(tick), 32'd1);
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cycle) begin
      e = exp_q.pop_front();
      check_output("tick_missing", 32'(cyc), 32'(e.cycle));
    end
  end

  initial begin
    apply_stimulus(0, 0, 0, 0, 0);
    repeat (3) step();
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_ready", 32'(cfg_ready), 32'd1);
    check_output("rst_clk", 32'(clk_out), 32'd1);
    check_output("rst_tick_done", {30'd0, tick, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Default configuration, continuous run
    $display("[TB] default H=2700 continuous");
    apply_stimulus(0, 0, 0, 1, 0);
    k = cyc + 1;
    push_ticks(k, 2700, 3, 1'b0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t1_busy", 32'(busy), 32'd1);
    goto_cycle(k + 2699);
    check_output("t1_clk_hi_end", 32'(clk_out), 32'd1);
    goto_cycle(k + 2700);
    check_output("t1_clk_lo_start", 32'(clk_out), 32'd0);
    goto_cycle(k + 5399);
    check_output("t1_clk_lo_end", 32'(clk_out), 32'd0);
    goto_cycle(k + 5400);
    check_output("t1_clk_hi_again", 32'(clk_out), 32'd1);
    goto_cycle(k + 8105);
    apply_stimulus(0, 0, 0, 0, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t1_stop_busy", 32'(busy), 32'd0);
    repeat (3) step();

    // Burst of six toggles with config and start in the same cycle
    $display("[TB] burst H=4 N=6");
    apply_stimulus(1, 4, 6, 1, 0);
    k = cyc + 1;
    push_ticks(k, 4, 6, 1'b1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t2_start_clk", 32'(clk_out), 32'd1);
    goto_cycle(k + 23);
    check_output("t2_busy_before_done", 32'(busy), 32'd1);
    goto_cycle(k + 24);
    check_output("t2_busy_after_done", 32'(busy), 32'd0);
    check_output("t2_clk_end", 32'(clk_out), 32'd1);
    goto_cycle(k + 30);

    // Shadow reconfiguration mid-run
    $display("[TB] shadow update H=10 -> 3");
    apply_stimulus(1, 10, 0, 1, 0);
    k = cyc + 1;
    push_ticks(k, 10, 2, 1'b0);
    push_ticks(k + 20, 3, 3, 1'b0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    goto_cycle(k + 12);
    apply_stimulus(1, 3, 0, 0, 0);
    check_output("t3_ready_idle_shadow", 32'(cfg_ready), 32'd1);
    step();
    check_output("t3_ready_pending", 32'(cfg_ready), 32'd0);
    goto_cycle(k + 19);
    check_output("t3_ready_still_pending", 32'(cfg_ready), 32'd0);
    goto_cycle(k + 20);
    check_output("t3_ready_after_toggle", 32'(cfg_ready), 32'd1);
    step();
    check_output("t3_second_cfg_taken", 32'(cfg_ready), 32'd0);
    apply_stimulus(0, 0, 0, 0, 0);
    goto_cycle(k + 23);
    check_output("t3_ready_second_applied", 32'(cfg_ready), 32'd1);
    goto_cycle(k + 30);
    apply_stimulus(0, 0, 0, 0, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t3_stop_busy", 32'(busy), 32'd0);
    repeat (3) step();

    // Stop in the toggle cycle suppresses the toggle
    $display("[TB] stop on toggle cycle H=5");
    apply_stimulus(1, 5, 0, 1, 0);
    k = cyc + 1;
    push_ticks(k, 5, 1, 1'b0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    goto_cycle(k + 9);
    check_output("t4_clk_before_stop", 32'(clk_out), 32'd0);
    apply_stimulus(0, 0, 0, 0, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t4_stop_busy", 32'(busy), 32'd0);
    check_output("t4_stop_clk_held", 32'(clk_out), 32'd0);
    goto_cycle(k + 15);
    check_output("t4_idle_clk_held", 32'(clk_out), 32'd0);
    apply_stimulus(0, 0, 0, 1, 0);
    k2 = cyc + 1;
    push_ticks(k2, 5, 1, 1'b0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t4_restart_clk", 32'(clk_out), 32'd1);
    check_output("t4_restart_busy", 32'(busy), 32'd1);
    goto_cycle(k2 + 6);
    apply_stimulus(0, 0, 0, 0, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    repeat (3) step();

    // Zero half-period behaves as one
    $display("[TB] H=0 N=2");
    apply_stimulus(1, 0, 2, 1, 0);
    k = cyc + 1;
    push_ticks(k, 1, 2, 1'b1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t5_busy_start", 32'(busy), 32'd1);
    goto_cycle(k + 1);
    check_output("t5_clk_first", 32'(clk_out), 32'd0);
    check_output("t5_busy_mid", 32'(busy), 32'd1);
    goto_cycle(k + 2);
    check_output("t5_busy_done", 32'(busy), 32'd0);
    check_output("t5_clk_end", 32'(clk_out), 32'd1);
    goto_cycle(k + 6);

    // Asynchronous reset mid-period with a pending shadow value
    $display("[TB] async reset during H=100 run");
    apply_stimulus(1, 100, 0, 1, 0);
    k = cyc + 1;
    push_ticks(k, 100, 1, 1'b0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    goto_cycle(k + 120);
    apply_stimulus(1, 9, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t6_ready_pending", 32'(cfg_ready), 32'd0);
    check_output("t6_clk_low", 32'(clk_out), 32'd0);
    goto_cycle(k + 150);
    #3 rst_n = 1'b0;
    #1;
    check_output("t6_async_busy", 32'(busy), 32'd0);
    check_output("t6_async_ready", 32'(cfg_ready), 32'd1);
    check_output("t6_async_clk", 32'(clk_out), 32'd1);
    check_output("t6_async_tick_done", {30'd0, tick, done}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    apply_stimulus(0, 0, 0, 1, 0);
    k3 = cyc + 1;
    push_ticks(k3, 2700, 1, 1'b0);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    goto_cycle(k3 + 2699);
    check_output("t6_default_half_clk", 32'(clk_out), 32'd1);
    goto_cycle(k3 + 2705);
    apply_stimulus(0, 0, 0, 0, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("t6_stop_busy", 32'(busy), 32'd0);
    repeat (3) step();

    check_output("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
